// File: rtl/weight_buffer_pkg.sv
// Shared definitions for the ping-pong weight buffer.
//   PARAM_W          : width of the runtime R/S filter dimension fields
//   words_per_filter : stream words needed to carry an R x S filter
//   param_valid      : legality of a runtime R/S pair against the maxima
package weight_buffer_pkg;

  localparam int unsigned PARAM_W = 4;

  function automatic int unsigned words_per_filter(input int unsigned r,
                                                   input int unsigned s,
                                                   input int unsigned elem_width,
                                                   input int unsigned input_width);
    return (r * s * elem_width + input_width - 1) / input_width;
  endfunction

  function automatic logic param_valid(input int unsigned r,
                                       input int unsigned s,
                                       input int unsigned max_r,
                                       input int unsigned max_s);
    return (r != 0) && (s != 0) && (r <= max_r) && (s <= max_s);
  endfunction

endpackage

// File: rtl/weight_bank.sv
// One bank of filter storage for the ping-pong weight buffer.
//   clk, rst        : clock, asynchronous active-high reset
//   start           : first word of a filter; latch r_in/s_in and zero storage
//   we              : place the EPW elements of word starting at (row, col)
//   r_in, s_in      : filter dimensions presented with the first word
//   row, col        : position of the word's first element
//   word            : packed elements, element 0 in the MSBs
//   data            : stored rows, row 0 in the MSBs, each row left-justified
//   r, s            : latched filter dimensions
//   nxt_row/nxt_col : position following the last element of word
module weight_bank
  import weight_buffer_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH = 32,
  parameter int unsigned ELEM_WIDTH  = 8,
  parameter int unsigned MAX_R       = 5,
  parameter int unsigned MAX_S       = 5,
  parameter int unsigned ROW_WIDTH   = MAX_S * ELEM_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         we,
  input  logic [PARAM_W-1:0]           r_in,
  input  logic [PARAM_W-1:0]           s_in,
  input  logic [PARAM_W-1:0]           row,
  input  logic [PARAM_W-1:0]           col,
  input  logic [INPUT_WIDTH-1:0]       word,
  output logic [MAX_R*ROW_WIDTH-1:0]   data,
  output logic [PARAM_W-1:0]           r,
  output logic [PARAM_W-1:0]           s,
  output logic [PARAM_W-1:0]           nxt_row,
  output logic [PARAM_W-1:0]           nxt_col
);

  localparam int unsigned EPW = INPUT_WIDTH / ELEM_WIDTH;

  logic [ROW_WIDTH-1:0] mem     [MAX_R];
  logic [ROW_WIDTH-1:0] mem_nxt [MAX_R];
  logic [PARAM_W-1:0]   r_eff, s_eff, rr, cc;

  // Walk the word's elements across (row, col). Matching against every
  // (row, col) with constant selects keeps all indices static; once the
  // walk passes row R the remaining elements of the last word are dropped.
  always_comb begin
    r_eff = start ? r_in : r;
    s_eff = start ? s_in : s;
    for (int unsigned i = 0; i < MAX_R; i++) begin
      mem_nxt[i] = start ? '0 : mem[i];
    end
    rr = row;
    cc = col;
    for (int unsigned k = 0; k < EPW; k++) begin
      if (rr < r_eff) begin
        for (int unsigned i = 0; i < MAX_R; i++) begin
          for (int unsigned c = 0; c < MAX_S; c++) begin
            if ((rr == PARAM_W'(i)) && (cc == PARAM_W'(c))) begin
              mem_nxt[i][ROW_WIDTH-1-c*ELEM_WIDTH -: ELEM_WIDTH] =
                word[INPUT_WIDTH-1-k*ELEM_WIDTH -: ELEM_WIDTH];
            end
          end
        end
        if (cc + 1'b1 == s_eff) begin
          cc = '0;
          rr = rr + 1'b1;
        end else begin
          cc = cc + 1'b1;
        end
      end
    end
    nxt_row = rr;
    nxt_col = cc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < MAX_R; i++) begin
        mem[i] <= '0;
      end
      r <= '0;
      s <= '0;
    end else begin
      if (start) begin
        r <= r_in;
        s <= s_in;
      end
      if (we) begin
        for (int unsigned i = 0; i < MAX_R; i++) begin
          mem[i] <= mem_nxt[i];
        end
      end
    end
  end

  for (genvar g = 0; g < MAX_R; g++) begin : g_flat
    assign data[(MAX_R-g)*ROW_WIDTH-1 -: ROW_WIDTH] = mem[g];
  end

endmodule

// File: rtl/weight_buffer_pp.sv
// Double-buffered weight buffer: unpacks a stream of packed weights into an
// R x S filter in the write bank while the consumer reads the other bank.
//   clk, rst            : clock, asynchronous active-high reset
//   wr_en, wr_valid     : producer handshake qualifiers
//   wr_data             : packed weights, first element in the MSBs
//   param_r, param_s    : filter dimensions, sampled on a filter's first word
//   wr_ready            : write bank can accept a word
//   full                : both banks hold complete filters
//   rd_valid            : read bank holds a complete filter
//   rd_release          : consumer done with the read bank
//   rd_data, rd_r, rd_s : read bank rows (row 0 in MSBs) and dimensions
//   err_param           : sticky flag, illegal dimensions seen on a first word
module weight_buffer_pp
  import weight_buffer_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH = 32,
  parameter int unsigned ELEM_WIDTH  = 8,
  parameter int unsigned MAX_R       = 5,
  parameter int unsigned MAX_S       = 5,
  parameter int unsigned ROW_WIDTH   = MAX_S * ELEM_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic                       wr_valid,
  input  logic [INPUT_WIDTH-1:0]     wr_data,
  input  logic [PARAM_W-1:0]         param_r,
  input  logic [PARAM_W-1:0]         param_s,
  output logic                       wr_ready,
  output logic                       full,
  output logic                       rd_valid,
  input  logic                       rd_release,
  output logic [MAX_R*ROW_WIDTH-1:0] rd_data,
  output logic [PARAM_W-1:0]         rd_r,
  output logic [PARAM_W-1:0]         rd_s,
  output logic                       err_param
);

  localparam int unsigned WCNT_W = 16;

  logic                       wr_ptr, rd_ptr;
  logic [1:0]                 valid, valid_nxt;
  logic [PARAM_W-1:0]         row_cnt, col_cnt;
  logic [WCNT_W-1:0]          wcnt;
  logic                       accept, first, pv, start, we, last, release_ok;
  logic [PARAM_W-1:0]         r_eff, s_eff;
  logic [1:0]                 start_b, we_b;
  logic [MAX_R*ROW_WIDTH-1:0] data_b [2];
  logic [PARAM_W-1:0]         r_b  [2];
  logic [PARAM_W-1:0]         s_b  [2];
  logic [PARAM_W-1:0]         nr_b [2];
  logic [PARAM_W-1:0]         nc_b [2];

  assign wr_ready = !valid[wr_ptr];
  assign full     = &valid;
  assign rd_valid = valid[rd_ptr];
  assign rd_data  = data_b[rd_ptr];
  assign rd_r     = r_b[rd_ptr];
  assign rd_s     = s_b[rd_ptr];

  // A first word carries the dimensions itself; later words use the values
  // the write bank latched, so mid-filter PARAM changes have no effect.
  // Release and completion always target different banks (one is valid,
  // the other is not), so both updates to valid can land in one cycle.
  always_comb begin
    accept     = wr_en & wr_valid & wr_ready;
    first      = (wcnt == '0);
    pv         = param_valid(32'(param_r), 32'(param_s), MAX_R, MAX_S);
    start      = accept & first & pv;
    we         = accept & (!first | pv);
    r_eff      = first ? param_r : r_b[wr_ptr];
    s_eff      = first ? param_s : s_b[wr_ptr];
    last       = we && ((32'(wcnt) + 1) >=
                        words_per_filter(32'(r_eff), 32'(s_eff), ELEM_WIDTH, INPUT_WIDTH));
    release_ok = rd_release & valid[rd_ptr];
    start_b         = '0;
    we_b            = '0;
    start_b[wr_ptr] = start;
    we_b[wr_ptr]    = we;
    valid_nxt = valid;
    if (last) begin
      valid_nxt[wr_ptr] = 1'b1;
    end
    if (release_ok) begin
      valid_nxt[rd_ptr] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      valid     <= '0;
      wcnt      <= '0;
      row_cnt   <= '0;
      col_cnt   <= '0;
      err_param <= 1'b0;
    end else begin
      valid <= valid_nxt;
      if (release_ok) begin
        rd_ptr <= !rd_ptr;
      end
      if (accept && first && !pv) begin
        err_param <= 1'b1;
      end
      if (last) begin
        wr_ptr  <= !wr_ptr;
        wcnt    <= '0;
        row_cnt <= '0;
        col_cnt <= '0;
      end else if (we) begin
        wcnt    <= wcnt + 1'b1;
        row_cnt <= nr_b[wr_ptr];
        col_cnt <= nc_b[wr_ptr];
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    weight_bank #(
      .INPUT_WIDTH (INPUT_WIDTH),
      .ELEM_WIDTH  (ELEM_WIDTH),
      .MAX_R       (MAX_R),
      .MAX_S       (MAX_S),
      .ROW_WIDTH   (ROW_WIDTH)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .start   (start_b[g]),
      .we      (we_b[g]),
      .r_in    (param_r),
      .s_in    (param_s),
      .row     (row_cnt),
      .col     (col_cnt),
      .word    (wr_data),
      .data    (data_b[g]),
      .r       (r_b[g]),
      .s       (s_b[g]),
      .nxt_row (nr_b[g]),
      .nxt_col (nc_b[g])
    );
  end

endmodule
